i2c_byte_receiver: RTL and testbench
====================================

# i2c_byte_receiver

Serial-line receiver that sits directly downstream of the I2C controller's `sda` output. It recovers the start condition, the 8-bit address and the 8-bit data byte, sampled one bit per `clk`. It filters frames by its own address and presents accepted bytes through a one-entry valid/ready holding register, with miss and overrun status. It is the target-side model and consumer for controller bring-up, and the first piece of the target datapath.

## Interface
- `OWN_ADDR`, default 8'hA9: address this receiver accepts.
- `START_LEN`, default 2: number of consecutive low `sda` samples that form a start condition, range 1–15.
- `clk` input 1: single clock; `sda_in` is sampled on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sda_in` input 1: serial line, idle high, MSB first.
- `rx_ready` input 1: consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `clear_err` input 1: clears sticky `overrun`.
- `rx_data` output 8: last accepted data byte.
- `rx_valid` output 1: holding register full.
- `busy` output 1: high in any state other than IDLE.
- `addr_miss` output 1: one-cycle pulse when a received address differs from `OWN_ADDR`.
- `overrun` output 1: sticky; a byte was dropped because the holding register was full.

## Operation
- FSM states:
  - IDLE: a low sample enters START with `low_cnt` = 1. If `START_LEN` = 1, it goes straight to ADDR.
  - START: each low sample increments `low_cnt`. At `START_LEN` low samples it goes to ADDR. A high sample before that returns to IDLE (glitch, no status change).
  - ADDR: shifts 8 samples in, MSB first. On the 8th sample it compares the full byte with `OWN_ADDR`:
    - match: go to DATA;
    - mismatch: pulse `addr_miss` and go to SKIP.
  - DATA: shifts 8 samples. On the 8th sample it writes the byte to the holding register and returns to IDLE.
  - SKIP: counts 8 samples, discards them, and returns to IDLE.
- The bit counter is 3-bit and wraps 7→0 at each field boundary. It clears on entry to ADDR.
- Holding register behaviour when DATA completes:
  - `rx_valid`=0: load `rx_data` and set `rx_valid`.
  - `rx_valid`=1 and `rx_ready`=1 in the same cycle: the old byte is consumed, the new byte loads, `rx_valid` stays 1, and there is no overrun.
  - `rx_valid`=1 and `rx_ready`=0: the new byte is dropped, `rx_data` is unchanged, and `overrun` sets.
- `rx_valid` falls on any cycle with `rx_ready` high and no simultaneous load.
- `overrun` clears on `clear_err`. If a set and a clear happen in the same cycle, the set wins.
- Back-to-back frames: IDLE evaluates the sample right after the last data or skip bit. No idle-high gap is required.

## Timing
- Reset values:
  - IDLE, `low_cnt` = 0, bit counter = 0;
  - `rx_data` = 8'h00;
  - `rx_valid`, `busy`, `addr_miss` and `overrun` all 0.
- Reset asserted mid-frame aborts the frame immediately. No byte is delivered and no status is raised.
- All outputs are registered.
- Latency: with the first start-low sampled at edge 0, the address MSB is at edge `START_LEN`. `addr_miss` or the match decision is at edge `START_LEN`+7. `rx_valid` rises after edge `START_LEN`+15, which is edge 17 at the defaults.
- `addr_miss` is high for exactly one cycle, following edge `START_LEN`+7.
- `busy` rises after edge 0 and falls after the last data or skip sample.

## Structure
- The shared package `i2c_pkg` holds:
  - `rx_state_t`, with prefixed members RX_IDLE, RX_START, RX_ADDR, RX_DATA and RX_SKIP so they do not collide with the controller's state names;
  - the default address constant `I2C_DEFAULT_ADDR` = 8'hA9;
  - the localparam `I2C_BYTE_W` = 8.
- One sub-module, `i2c_shift_in`: an 8-bit MSB-first shift register with a 3-bit counter and a `done` strobe on the 8th bit. It is instantiated once and reused for the ADDR, DATA and SKIP phases.

## Test plan
- Frame: low ×2, address A9, data 3C, with `rx_ready`=1 → `rx_data`=8'h3C, `rx_valid` high after edge 17, `addr_miss` never pulses.
- Frame with address A8, data 55 → `addr_miss` pulses once after edge 9, `rx_valid` stays 0, `busy` drops after edge 17.
- Single low sample followed by a high sample → stays in or returns to IDLE, no status, and a following valid frame (A9/0F) is received correctly.
- Two A9 frames back-to-back (data 11 then 22) with `rx_ready`=0 → `rx_data`=8'h11, `overrun`=1. Then `rx_ready`=1 → `rx_valid` falls. Then `clear_err` → `overrun`=0.
- Second frame completes on the same cycle that `rx_ready`=1 accepts 8'h11 → `rx_data`=8'h22, `rx_valid` stays 1, `overrun`=0.
- `rst_n` pulsed low during the DATA bits of an A9 frame → all outputs return to 0 immediately, and the next full frame (A9/C3) delivers 8'hC3.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver state encoding, byte width and default target address.
package i2c_pkg;

  localparam int unsigned I2C_BYTE_W = 8;
  localparam logic [I2C_BYTE_W-1:0] I2C_DEFAULT_ADDR = 8'hA9;

  // Prefixed so they coexist with the controller's own state names
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_ADDR,
    RX_DATA,
    RX_SKIP
  } rx_state_t;

endpackage

// File: rtl/i2c_byte_receiver_if.sv
// Serial input, consumer handshake and status bundle of the I2C byte receiver.
interface i2c_byte_receiver_if;
  import i2c_pkg::*;

  logic                  sda_in;
  logic                  rx_ready;
  logic                  clear_err;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  addr_miss;
  logic                  overrun;

  modport master (
    output sda_in, rx_ready, clear_err,
    input  rx_data, rx_valid, busy, addr_miss, overrun
  );

  modport slave (
    input  sda_in, rx_ready, clear_err,
    output rx_data, rx_valid, busy, addr_miss, overrun
  );

endinterface

// File: rtl/i2c_shift_in.sv
// MSB-first byte deserializer; byte_c/done_c present the full byte on the cycle the 8th bit arrives.
module i2c_shift_in
  import i2c_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  bit_in,
  output logic [I2C_BYTE_W-1:0] byte_c,
  output logic                  done_c
);

  localparam int unsigned CNT_W = 3;

  // Only the 7 earlier bits are stored; the 8th comes straight from bit_in
  logic [I2C_BYTE_W-2:0] shreg_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      cnt_q   <= '0;
    end else if (en) begin
      cnt_q   <= CNT_W'(cnt_q + 1'b1);
      shreg_q <= {shreg_q[I2C_BYTE_W-3:0], bit_in};
    end
  end

  assign byte_c = {shreg_q, bit_in};
  assign done_c = en && (cnt_q == CNT_W'(I2C_BYTE_W - 1));

endmodule

// File: rtl/i2c_byte_receiver.sv
// Target-side I2C frame receiver: start detect, address filter, data byte into a valid/ready holding register.
module i2c_byte_receiver
  import i2c_pkg::*;
#(
  parameter logic [I2C_BYTE_W-1:0] OWN_ADDR  = I2C_DEFAULT_ADDR,
  parameter int unsigned           START_LEN = 2
)(
  input  logic                clk,
  input  logic                rst_n,
  i2c_byte_receiver_if.slave  bus
);

  localparam int unsigned LOW_W = 4;

  rx_state_t             state_q, state_d;
  logic [LOW_W-1:0]      low_cnt_q, low_cnt_d, low_cnt_inc;
  logic                  shift_en, shift_clr;
  logic                  byte_done;
  logic [I2C_BYTE_W-1:0] shift_byte;
  logic                  load, miss;

  logic [I2C_BYTE_W-1:0] rx_data_q;
  logic                  rx_valid_q, busy_q, addr_miss_q, overrun_q;

  i2c_shift_in u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (shift_clr),
    .en     (shift_en),
    .bit_in (bus.sda_in),
    .byte_c (shift_byte),
    .done_c (byte_done)
  );

  assign low_cnt_inc = LOW_W'(low_cnt_q + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      low_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    shift_en  = 1'b0;
    shift_clr = 1'b0;
    load      = 1'b0;
    miss      = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!bus.sda_in) begin
          if (START_LEN == 1) begin
            state_d   = RX_ADDR;
            shift_clr = 1'b1;
          end else begin
            state_d   = RX_START;
            low_cnt_d = LOW_W'(1);
          end
        end
      end
      RX_START: begin
        if (!bus.sda_in) begin
          low_cnt_d = low_cnt_inc;
          if (low_cnt_inc == LOW_W'(START_LEN)) begin
            state_d   = RX_ADDR;
            low_cnt_d = '0;
            shift_clr = 1'b1;
          end
        end else begin
          // Glitch: too short to be a start, drop silently
          state_d   = RX_IDLE;
          low_cnt_d = '0;
        end
      end
      RX_ADDR: begin
        shift_en = 1'b1;
        if (byte_done) begin
          if (shift_byte == OWN_ADDR) begin
            state_d = RX_DATA;
          end else begin
            state_d = RX_SKIP;
            miss    = 1'b1;
          end
        end
      end
      RX_DATA: begin
        shift_en = 1'b1;
        if (byte_done) begin
          state_d = RX_IDLE;
          load    = 1'b1;
        end
      end
      RX_SKIP: begin
        shift_en = 1'b1;
        if (byte_done) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Holding register and status; a load during a same-cycle accept replaces the old byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      addr_miss_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      busy_q      <= (state_d != RX_IDLE);
      addr_miss_q <= miss;
      if (load) begin
        if (!rx_valid_q || bus.rx_ready) begin
          rx_data_q  <= shift_byte;
          rx_valid_q <= 1'b1;
        end
      end else if (bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (load && rx_valid_q && !bus.rx_ready) begin
        overrun_q <= 1'b1;
      end else if (bus.clear_err) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.addr_miss = addr_miss_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// Self-checking bench for i2c_byte_receiver: frame table plus hand-written overrun/reset sequences.
module tb_i2c_byte_receiver;
  import i2c_pkg::*;

  localparam logic [7:0] OWN       = 8'hA9;
  localparam int         START_LEN = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] sb[$];

  i2c_byte_receiver_if bus ();

  i2c_byte_receiver #(.OWN_ADDR(OWN), .START_LEN(START_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_miss;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One sample; a handshake seen before the edge pops the scoreboard
  task automatic tick(input logic b);
    logic       hs;
    logic [7:0] d;
    logic [7:0] e;
    bus.sda_in = b;
    hs = rst_n && bus.rx_valid && bus.rx_ready;
    d  = bus.rx_data;
    @(posedge clk);
    #1;
    if (hs) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(d), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_data", 32'(d), 32'(e));
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [7:0] data,
                            input logic rdy, input logic rdy_last);
    int miss;
    miss = 0;
    bus.rx_ready = rdy;
    for (int i = 0; i < START_LEN; i++) begin
      tick(1'b0);
      if (i == 0) check("busy_rise", 32'(bus.busy), 32'd1);
    end
    for (int i = 7; i >= 0; i--) begin
      tick(addr[i]);
      if (bus.addr_miss) miss++;
      if (i == 0) check("miss_at_decision", 32'(bus.addr_miss), 32'(addr != OWN));
    end
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) bus.rx_ready = rdy_last;
      tick(data[i]);
      if (bus.addr_miss) miss++;
    end
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("miss_count", 32'(miss), 32'(addr != OWN));
  endtask

  vec_t vecs[6];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{addr: 8'hA9, data: 8'h3C, exp_miss: 1'b0};
    vecs[1] = '{addr: 8'hA8, data: 8'h55, exp_miss: 1'b1};
    vecs[2] = '{addr: 8'hA9, data: 8'h00, exp_miss: 1'b0};
    vecs[3] = '{addr: 8'h01, data: 8'hA9, exp_miss: 1'b1};
    vecs[4] = '{addr: 8'hA9, data: 8'hFF, exp_miss: 1'b0};
    vecs[5] = '{addr: 8'hA9, data: 8'hA5, exp_miss: 1'b0};

    bus.sda_in    = 1'b1;
    bus.rx_ready  = 1'b1;
    bus.clear_err = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data",   32'(bus.rx_data),   32'h00);
    check("rst_rx_valid",  32'(bus.rx_valid),  32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_addr_miss", 32'(bus.addr_miss), 32'd0);
    check("rst_overrun",   32'(bus.overrun),   32'd0);
    rst_n = 1'b1;
    tick(1'b1);
    tick(1'b1);

    // Table: frames back-to-back, consumer always ready
    foreach (vecs[k]) begin
      if (!vecs[k].exp_miss) sb.push_back(vecs[k].data);
      send_frame(vecs[k].addr, vecs[k].data, 1'b1, 1'b1);
      check("valid_after_frame", 32'(bus.rx_valid), 32'(!vecs[k].exp_miss));
      if (!vecs[k].exp_miss) check("data_after_frame", 32'(bus.rx_data), 32'(vecs[k].data));
    end
    tick(1'b1);
    check("valid_fall_ready", 32'(bus.rx_valid), 32'd0);

    // Glitch: single low then high
    tick(1'b0);
    check("glitch_busy", 32'(bus.busy), 32'd1);
    tick(1'b1);
    check("glitch_idle", 32'(bus.busy), 32'd0);
    check("glitch_miss", 32'(bus.addr_miss), 32'd0);
    check("glitch_valid", 32'(bus.rx_valid), 32'd0);
    sb.push_back(8'h0F);
    send_frame(OWN, 8'h0F, 1'b1, 1'b1);
    check("glitch_next_data", 32'(bus.rx_data), 32'h0F);
    tick(1'b1);

    // Overrun: two frames with consumer stalled, then set-vs-clear in same cycle
    sb.push_back(8'h11);
    send_frame(OWN, 8'h11, 1'b0, 1'b0);
    check("ovr_first_valid", 32'(bus.rx_valid), 32'd1);
    send_frame(OWN, 8'h22, 1'b0, 1'b0);
    check("ovr_data_kept", 32'(bus.rx_data), 32'h11);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    bus.clear_err = 1'b1;
    tick(1'b1);
    check("ovr_cleared", 32'(bus.overrun), 32'd0);
    send_frame(OWN, 8'h33, 1'b0, 1'b0);
    check("ovr_set_wins", 32'(bus.overrun), 32'd1);
    check("ovr_data_kept2", 32'(bus.rx_data), 32'h11);
    bus.clear_err = 1'b0;
    bus.rx_ready  = 1'b1;
    tick(1'b1);
    check("ovr_valid_fall", 32'(bus.rx_valid), 32'd0);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    bus.rx_ready  = 1'b0;
    bus.clear_err = 1'b1;
    tick(1'b1);
    bus.clear_err = 1'b0;
    check("ovr_clear", 32'(bus.overrun), 32'd0);

    // Load coincides with accept of the held byte
    sb.push_back(8'h11);
    send_frame(OWN, 8'h11, 1'b0, 1'b0);
    sb.push_back(8'h22);
    send_frame(OWN, 8'h22, 1'b0, 1'b1);
    check("sim_data", 32'(bus.rx_data), 32'h22);
    check("sim_valid", 32'(bus.rx_valid), 32'd1);
    check("sim_overrun", 32'(bus.overrun), 32'd0);
    tick(1'b1);
    check("sim_drained", 32'(bus.rx_valid), 32'd0);

    // Reset mid-frame with a byte still held
    bus.rx_ready = 1'b0;
    send_frame(OWN, 8'h5A, 1'b0, 1'b0);
    send_frame(OWN, 8'h66, 1'b0, 1'b0);
    for (int i = 0; i < START_LEN; i++) tick(1'b0);
    for (int i = 7; i >= 0; i--) tick(OWN[i]);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   32'(bus.rx_valid),  32'd0);
    check("mid_rst_data",    32'(bus.rx_data),   32'h00);
    check("mid_rst_busy",    32'(bus.busy),      32'd0);
    check("mid_rst_overrun", 32'(bus.overrun),   32'd0);
    check("mid_rst_miss",    32'(bus.addr_miss), 32'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.rx_ready = 1'b1;
    tick(1'b1);
    sb.push_back(8'hC3);
    send_frame(OWN, 8'hC3, 1'b1, 1'b1);
    check("post_rst_data", 32'(bus.rx_data), 32'hC3);
    check("post_rst_valid", 32'(bus.rx_valid), 32'd1);
    repeat (3) tick(1'b1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
